// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the LEGv8 MEM stage: FSM encoding, alignment mask,
// MEM/WB control-field layout and its bubble value.
package mem_access_stage_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [2:0] ALIGN_MASK = 3'b111;

  typedef struct packed {
    logic [4:0] write_reg;
    logic       regwrite;
    logic       memtoreg;
    logic       valid;
  } wb_ctrl_t;

  localparam wb_ctrl_t WB_CTRL_BUBBLE = '0;

  function automatic logic is_misaligned(input logic [2:0] addr_low, input logic check_en);
    return check_en && ((addr_low & ALIGN_MASK) != 3'b000);
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB boundary register. bubble wins over load; with neither asserted the contents hold.
module mem_wb_reg
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              bubble,
  input  logic [DATA_W-1:0] read_data_d,
  input  logic [DATA_W-1:0] alu_result_d,
  input  wb_ctrl_t          ctrl_d,
  output logic [DATA_W-1:0] read_data_q,
  output logic [DATA_W-1:0] alu_result_q,
  output wb_ctrl_t          ctrl_q
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_data_q  <= '0;
      alu_result_q <= '0;
      ctrl_q       <= WB_CTRL_BUBBLE;
    end else if (bubble) begin
      read_data_q  <= '0;
      alu_result_q <= '0;
      ctrl_q       <= WB_CTRL_BUBBLE;
    end else if (load) begin
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      ctrl_q       <= ctrl_d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// LEGv8 MEM stage: issues data-memory accesses over req/ack, stalls upstream while waiting,
// aborts on timeout or misalignment, and feeds the MEM/WB register.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 16,
  parameter int ALIGN_CHECK = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] Add_result,
  input  logic [DATA_W-1:0] Alu_result,
  input  logic              Zero,
  input  logic [DATA_W-1:0] Read2,
  input  logic [4:0]        Write_reg,
  input  logic              Branch,
  input  logic              Memread,
  input  logic              Memwrite,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              pc_src,
  output logic [DATA_W-1:0] branch_target,
  output logic              mem_fault,
  output logic [DATA_W-1:0] Read_data_wb,
  output logic [DATA_W-1:0] Alu_result_wb,
  output logic [4:0]        Write_reg_wb,
  output logic              RegWrite_wb,
  output logic              MemtoReg_wb,
  output logic              wb_valid,
  output state_t            dbg_state
);

  // Handshake: mem_req rises on the edge leaving IDLE and stays high, with mem_addr,
  // mem_wdata and mem_we frozen, until the edge that samples mem_ack=1 (a one-cycle
  // pulse carrying mem_rdata) or until the timeout abort. mem_ack outside WAIT is ignored.

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              access, misaligned;
  logic              start_acc, end_acc, fault_d;
  logic              wb_load, wb_bubble;
  logic [DATA_W-1:0] wb_rdata_d, wb_alu_d;
  wb_ctrl_t          wb_ctrl_d, wb_ctrl_q, held_ctrl_q;

  assign access        = Memread | Memwrite;
  assign misaligned    = is_misaligned(Alu_result[2:0], ALIGN_CHECK != 0);
  assign pc_src        = Branch & Zero;
  assign branch_target = Add_result;
  assign dbg_state     = state_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall      = 1'b0;
    start_acc  = 1'b0;
    end_acc    = 1'b0;
    fault_d    = 1'b0;
    wb_load    = 1'b0;
    wb_bubble  = 1'b0;
    wb_rdata_d = '0;
    wb_alu_d   = Alu_result;
    wb_ctrl_d  = '{write_reg: Write_reg, regwrite: RegWrite, memtoreg: MemtoReg, valid: 1'b1};
    case (state_q)
      ST_IDLE: begin
        if (!access) begin
          wb_load = 1'b1;
        end else if (misaligned) begin
          wb_load            = 1'b1;
          wb_ctrl_d.regwrite = 1'b0;
          fault_d            = 1'b1;
        end else begin
          stall     = 1'b1;
          start_acc = 1'b1;
          wb_bubble = 1'b1;
          cnt_d     = 8'd0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // mem_addr doubles as the held ALU result of the instruction in flight.
        stall     = !mem_ack;
        wb_alu_d  = mem_addr;
        wb_ctrl_d = held_ctrl_q;
        if (mem_ack) begin
          wb_load    = 1'b1;
          wb_rdata_d = mem_we ? '0 : mem_rdata;
          end_acc    = 1'b1;
          cnt_d      = 8'd0;
          state_d    = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          wb_load            = 1'b1;
          wb_ctrl_d.regwrite = 1'b0;
          fault_d            = 1'b1;
          end_acc            = 1'b1;
          cnt_d              = 8'd0;
          state_d            = ST_IDLE;
        end else begin
          wb_bubble = 1'b1;
          cnt_d     = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      held_ctrl_q <= WB_CTRL_BUBBLE;
      mem_fault   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_fault <= fault_d;
      if (start_acc) begin
        mem_req     <= 1'b1;
        mem_we      <= Memwrite;
        mem_addr    <= Alu_result;
        mem_wdata   <= Read2;
        held_ctrl_q <= '{write_reg: Write_reg, regwrite: RegWrite, memtoreg: MemtoReg, valid: 1'b1};
      end else if (end_acc) begin
        mem_req <= 1'b0;
      end
    end
  end

  mem_wb_reg #(.DATA_W(DATA_W)) u_mem_wb_reg (
    .clock        (clock),
    .reset_n      (reset_n),
    .load         (wb_load),
    .bubble       (wb_bubble),
    .read_data_d  (wb_rdata_d),
    .alu_result_d (wb_alu_d),
    .ctrl_d       (wb_ctrl_d),
    .read_data_q  (Read_data_wb),
    .alu_result_q (Alu_result_wb),
    .ctrl_q       (wb_ctrl_q)
  );

  assign Write_reg_wb = wb_ctrl_q.write_reg;
  assign RegWrite_wb  = wb_ctrl_q.regwrite;
  assign MemtoReg_wb  = wb_ctrl_q.memtoreg;
  assign wb_valid     = wb_ctrl_q.valid;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios then randomized instructions, each
// transaction's MEM/WB result predicted from the stage's rules and queued for comparison.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int DW = 64;
  localparam int TO = 16;
  localparam int EW = 2 * DW + 8;

  logic          clock, reset_n;
  logic [DW-1:0] Add_result, Alu_result, Read2, mem_rdata;
  logic [4:0]    Write_reg;
  logic          Zero, Branch, Memread, Memwrite, RegWrite, MemtoReg, mem_ack;
  logic          mem_req, mem_we, stall, pc_src, mem_fault;
  logic [DW-1:0] mem_addr, mem_wdata, branch_target, Read_data_wb, Alu_result_wb;
  logic [4:0]    Write_reg_wb;
  logic          RegWrite_wb, MemtoReg_wb, wb_valid;
  state_t        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];

  mem_access_stage #(.DATA_W(DW), .TIMEOUT_CYC(TO), .ALIGN_CHECK(1)) dut (
    .clock(clock), .reset_n(reset_n), .Add_result(Add_result), .Alu_result(Alu_result),
    .Zero(Zero), .Read2(Read2), .Write_reg(Write_reg), .Branch(Branch), .Memread(Memread),
    .Memwrite(Memwrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
    .mem_fault(mem_fault), .Read_data_wb(Read_data_wb), .Alu_result_wb(Alu_result_wb),
    .Write_reg_wb(Write_reg_wb), .RegWrite_wb(RegWrite_wb), .MemtoReg_wb(MemtoReg_wb),
    .wb_valid(wb_valid), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] wb_rec(input logic [DW-1:0] rd, input logic [DW-1:0] alu,
                                           input logic [4:0] wr, input logic rw,
                                           input logic m2r, input logic v);
    return {rd, alu, wr, rw, m2r, v};
  endfunction

  task automatic check_wb(input string tag);
    logic [EW-1:0] e;
    check({tag, ".q_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check({tag, ".rdata_wb"}, Read_data_wb, e[EW-1 -: DW]);
    check({tag, ".alu_wb"}, Alu_result_wb, e[EW-DW-1 -: DW]);
    check({tag, ".wreg_wb"}, 64'(Write_reg_wb), 64'(e[7:3]));
    check({tag, ".regwrite_wb"}, 64'(RegWrite_wb), 64'(e[2]));
    check({tag, ".memtoreg_wb"}, 64'(MemtoReg_wb), 64'(e[1]));
    check({tag, ".wb_valid"}, 64'(wb_valid), 64'(e[0]));
  endtask

  // driver tasks
  task automatic drive_instr(input logic [DW-1:0] alu, input logic [DW-1:0] add,
                             input logic [DW-1:0] r2, input logic [4:0] wr, input logic br,
                             input logic z, input logic mr, input logic mw, input logic rw,
                             input logic m2r);
    Alu_result = alu; Add_result = add; Read2 = r2; Write_reg = wr; Branch = br;
    Zero = z; Memread = mr; Memwrite = mw; RegWrite = rw; MemtoReg = m2r;
  endtask

  // Called at posedge+1 with the instruction already driven. lat = WAIT cycle index in
  // which mem_ack is returned; lat >= TO means the memory never answers.
  task automatic run_instr(input string tag, input int lat, input logic [DW-1:0] rdata);
    logic acc, mis, wr_op, alu_rw;
    logic [DW-1:0] alu, r2;
    alu = Alu_result; r2 = Read2; alu_rw = RegWrite;
    acc = Memread | Memwrite;
    mis = (alu[2:0] != 3'b000);
    wr_op = Memwrite;
    if (!acc) begin
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = {$urandom, $urandom};
      exp_q.push_back(wb_rec('0, alu, Write_reg, alu_rw, MemtoReg, 1'b1));
      @(negedge clock);
      check({tag, ".stall"}, 64'(stall), 64'd0);
      check({tag, ".pc_src"}, 64'(pc_src), 64'(Branch & Zero));
      check({tag, ".br_target"}, branch_target, Add_result);
      @(posedge clock); #1;
      mem_ack = 1'b0;
      check_wb(tag);
      check({tag, ".req"}, 64'(mem_req), 64'd0);
      check({tag, ".fault"}, 64'(mem_fault), 64'd0);
    end else if (mis) begin
      exp_q.push_back(wb_rec('0, alu, Write_reg, 1'b0, MemtoReg, 1'b1));
      @(negedge clock);
      check({tag, ".stall"}, 64'(stall), 64'd0);
      @(posedge clock); #1;
      check_wb(tag);
      check({tag, ".req"}, 64'(mem_req), 64'd0);
      check({tag, ".fault"}, 64'(mem_fault), 64'd1);
      check({tag, ".state"}, 64'(dbg_state), 64'(ST_IDLE));
    end else begin
      @(negedge clock);
      check({tag, ".stall_idle"}, 64'(stall), 64'd1);
      @(posedge clock); #1;
      exp_q.push_back(wb_rec('0, '0, 5'd0, 1'b0, 1'b0, 1'b0));
      check_wb({tag, ".bubble0"});
      for (int k = 0; k < TO; k++) begin
        check({tag, ".req"}, 64'(mem_req), 64'd1);
        check({tag, ".addr"}, mem_addr, alu);
        check({tag, ".we"}, 64'(mem_we), 64'(wr_op));
        if (wr_op) check({tag, ".wdata"}, mem_wdata, r2);
        check({tag, ".state"}, 64'(dbg_state), 64'(ST_WAIT));
        if (k == lat) begin
          mem_ack = 1'b1;
          mem_rdata = rdata;
        end
        @(negedge clock);
        check({tag, ".stall_wait"}, 64'(stall), 64'(k != lat));
        @(posedge clock); #1;
        if (k == lat) begin
          mem_ack = 1'b0;
          mem_rdata = {$urandom, $urandom};
          exp_q.push_back(wb_rec(wr_op ? '0 : rdata, alu, Write_reg, alu_rw, MemtoReg, 1'b1));
          check_wb({tag, ".done"});
          check({tag, ".fault"}, 64'(mem_fault), 64'd0);
          check({tag, ".req_end"}, 64'(mem_req), 64'd0);
          break;
        end else if (k == TO - 1) begin
          exp_q.push_back(wb_rec('0, alu, Write_reg, 1'b0, MemtoReg, 1'b1));
          check_wb({tag, ".timeout"});
          check({tag, ".fault"}, 64'(mem_fault), 64'd1);
          check({tag, ".req_end"}, 64'(mem_req), 64'd0);
          check({tag, ".state_end"}, 64'(dbg_state), 64'(ST_IDLE));
        end else begin
          exp_q.push_back(wb_rec('0, '0, 5'd0, 1'b0, 1'b0, 1'b0));
          check_wb({tag, ".bubble"});
        end
      end
    end
  endtask

  initial begin
    logic [DW-1:0] a;
    int kind, lat;
    reset_n = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    drive_instr('0, '0, '0, 5'd0, 0, 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    check("reset.req", 64'(mem_req), 64'd0);
    check("reset.we", 64'(mem_we), 64'd0);
    check("reset.addr", mem_addr, 64'd0);
    check("reset.wb_valid", 64'(wb_valid), 64'd0);
    check("reset.fault", 64'(mem_fault), 64'd0);
    check("reset.state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;

    drive_instr(64'h2A, 64'h0, 64'h0, 5'd5, 0, 0, 0, 0, 1, 0);
    run_instr("alu_op", 0, '0);
    drive_instr(64'h100, 64'h0, 64'h0, 5'd9, 0, 0, 1, 0, 1, 1);
    run_instr("load_100", 3, 64'hDEADBEEF);
    drive_instr(64'h108, 64'h0, 64'h55, 5'd0, 0, 0, 0, 1, 0, 0);
    run_instr("store_108", 1, 64'h1234);
    drive_instr(64'h103, 64'h0, 64'h0, 5'd3, 0, 0, 1, 0, 1, 1);
    run_instr("load_103", 0, '0);
    drive_instr(64'h200, 64'h0, 64'h0, 5'd7, 0, 0, 1, 0, 1, 1);
    run_instr("timeout", 99, '0);
    drive_instr(64'h208, 64'h0, 64'h0, 5'd8, 0, 0, 1, 0, 1, 1);
    run_instr("ack_last", TO - 1, 64'hCAFEF00D);
    drive_instr(64'h310, 64'h0, 64'hAB, 5'd4, 0, 0, 1, 1, 0, 0);
    run_instr("rd_and_wr", 0, 64'h77);

    // reset two cycles into WAIT
    drive_instr(64'h400, 64'h0, 64'h0, 5'd6, 0, 0, 1, 0, 1, 1);
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid.req", 64'(mem_req), 64'd0);
    check("rst_mid.rdata_wb", Read_data_wb, 64'd0);
    check("rst_mid.alu_wb", Alu_result_wb, 64'd0);
    check("rst_mid.wreg_wb", 64'(Write_reg_wb), 64'd0);
    check("rst_mid.wb_valid", 64'(wb_valid), 64'd0);
    check("rst_mid.state", 64'(dbg_state), 64'(ST_IDLE));
    drive_instr('0, '0, '0, 5'd0, 0, 0, 0, 0, 0, 0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    drive_instr(64'h18, 64'h40, 64'h0, 5'd0, 1, 1, 0, 0, 0, 0);
    run_instr("branch", 0, '0);

    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 3));
      a = {$urandom, $urandom};
      if (kind != 0 && $urandom_range(0, 4) != 0) a[2:0] = 3'b000;
      lat = int'($urandom_range(0, 19));
      drive_instr(a, {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom),
                  1'($urandom), 1'($urandom), kind == 1 || kind == 3, kind >= 2,
                  1'($urandom), 1'($urandom));
      run_instr($sformatf("rand%0d", i), lat, {$urandom, $urandom});
    end

    check("final.q_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
